frame_buffer: RTL
=================

FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 Parameter DATA_W, 8, pixel width in bits.
REQ-002 Parameter H_RES, 640, pixels per line.
REQ-003 Parameter V_RES, 480, lines per frame; DEPTH = H_RES*V_RES, ADDR_W = clog2(DEPTH).
REQ-004 Parameter CLEAR_VAL, 254, value written by init and clear sweeps.
REQ-005 One clock; reset is synchronous and active-high, named clk and reset.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 we / write_addr / data_in  in  1 / ADDR_W / DATA_W  write port into back bank.
REQ-009 re / read_addr  in  1 / ADDR_W  read port from front bank.
REQ-010 data_out  out  DATA_W  registered read data.
REQ-011 clear_start  in  1  single-cycle request to fill back bank with CLEAR_VAL.
REQ-012 swap_req  in  1  single-cycle request to exchange front and back banks.
REQ-013 busy / clear_done / swap_ack  out  1 each  sweep active / one-cycle clear-finished pulse / one-cycle swap pulse.
REQ-014 initialized / front_sel  out  1 each  power-up fill complete (sticky) / index of bank being read.

Function
REQ-015 FSM states INIT, IDLE, CLEAR; INIT entered from reset, CLEAR from IDLE on clear_start.
REQ-016 INIT writes CLEAR_VAL to address k of every bank on its k-th cycle, k = 0..DEPTH-1; on the cycle after address DEPTH-1, initialized=1 and state=IDLE.
REQ-017 CLEAR writes CLEAR_VAL to back bank, one address per cycle from 0 to DEPTH-1; busy=1 from the cycle after clear_start through the last write; clear_done pulses and busy drops on the following cycle.
REQ-018 busy=1 throughout INIT; clear_start while busy or in INIT is ignored (not queued).
REQ-019 Writes with we=1 during INIT or CLEAR are dropped; writes with write_addr >= DEPTH are dropped.
REQ-020 Read latency exactly 1 cycle: data_out updates on the edge where re=1, holds otherwise; read_addr >= DEPTH returns CLEAR_VAL.
REQ-021 Reads are served from the front bank in every state, including during INIT (returning undefined until initialized=1) and CLEAR.
REQ-022 swap_req in IDLE toggles front_sel on that edge and pulses swap_ack the next cycle.
REQ-023 swap_req during CLEAR sets a single pending flag; swap executes on the clear_done cycle, swap_ack one cycle later; further swap_req while pending are merged.
REQ-024 Simultaneous clear_start and swap_req in IDLE: swap first, then clear sweeps the new back bank.
REQ-025 Simultaneous we and re to same bank/address is impossible by construction (distinct banks); no bypass required.

Reset
REQ-026 Reset: state=INIT, sweep counter=0, initialized=0, front_sel=0, busy=1, clear_done=0, swap_ack=0, data_out=0, pending swap cleared.
REQ-027 Reset mid-INIT or mid-CLEAR abandons the sweep and restarts INIT from address 0; memory array itself has no reset.

Configuration
REQ-028 Macro FRAME_BUFFER_DOUBLE_EN defined: two banks, swap logic as above.
REQ-029 Macro undefined: one bank used for read and write; front_sel tied 0; swap_req acts as swap_ack echo (pulse next cycle, no state change); reads during CLEAR return partially cleared data.

Structure
REQ-030 Package fb_pkg holds default resolution constants, CLEAR_VAL default and the FSM state enum.
REQ-031 One sub-module fb_bank: simple dual-port DATA_W x DEPTH RAM, one write port, one registered read port, instantiated once or twice.

Verification
REQ-032 Reset then idle -> busy=1 for 307200 cycles, initialized=1 on cycle 307200, reads of 0, 1000, 307199 after swap return 254.
REQ-033 Write 0x5A to addr 100, swap_req, re addr 100 -> data_out=0x5A one cycle after re, front_sel=1, swap_ack pulse.
REQ-034 clear_start, then swap_req 10 cycles later -> swap deferred, clear_done then swap_ack on consecutive cycles, front bank all 254.
REQ-035 we=1 addr 50 during CLEAR and addr 307200 in IDLE -> both dropped, back bank addr 50 reads 254 after swap.
REQ-036 reset asserted at INIT address 1000 -> restart at 0, initialized=0 until full 307200-cycle sweep completes.
REQ-037 Build without FRAME_BUFFER_DOUBLE_EN: write 0x11 addr 7, read addr 7 -> 0x11 after 1 cycle, front_sel stays 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Frame buffer shared constants and FSM state encoding.
// Default resolution, default clear value and sweep FSM states.
package fb_pkg;

  localparam int H_RES_DEF     = 640;
  localparam int V_RES_DEF     = 480;
  localparam int CLEAR_VAL_DEF = 254;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_bank.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// Ports: clk_i, reset_i, we_i/waddr_i/wdata_i, re_i/raddr_i, rdata_o.
module fb_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640 * 480,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer.sv
// Frame buffer with init/clear sweeps; FRAME_BUFFER_DOUBLE_EN selects
// two swappable banks. Ports: clk, reset, write/read ports, sweep/swap status.
module frame_buffer
  import fb_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                H_RES     = H_RES_DEF,
  parameter int                V_RES     = V_RES_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(CLEAR_VAL_DEF),
  parameter int                DEPTH     = H_RES * V_RES,
  parameter int                ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              re,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] data_out,
  input  logic              clear_start,
  input  logic              swap_req,
  output logic              busy,
  output logic              clear_done,
  output logic              swap_ack,
  output logic              initialized,
  output logic              front_sel
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_q, init_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_q, ack_d;
  logic              oor_q;

  logic              wr_ok, rd_ok, sweeping, user_we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign wr_ok    = {1'b0, write_addr} < DEPTH_X;
  assign rd_ok    = {1'b0, read_addr} < DEPTH_X;
  assign sweeping = state_q != ST_IDLE;
  assign user_we  = (state_q == ST_IDLE) && we && wr_ok;
  assign waddr    = sweeping ? cnt_q : write_addr;
  assign wdata    = sweeping ? CLEAR_VAL : data_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          init_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_start) begin
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      init_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      if (re) oor_q <= !rd_ok;
    end
  end

  assign busy        = busy_q;
  assign clear_done  = done_q;
  assign swap_ack    = ack_q;
  assign initialized = init_q;

`ifdef FRAME_BUFFER_DOUBLE_EN
  logic              front_q, front_d;
  logic              pend_q, pend_d;
  logic              rsel_q;
  logic              do_swap;
  logic [1:0]        bank_we;
  logic [DATA_W-1:0] rd0, rd1;

  // A swap held over from CLEAR fires in the first IDLE cycle,
  // which is the cycle clear_done is high.
  always_comb begin
    do_swap = (state_q == ST_IDLE) && (swap_req || pend_q);
    front_d = front_q ^ do_swap;
    pend_d  = pend_q && !do_swap;
    if ((state_q == ST_CLEAR) && swap_req) pend_d = 1'b1;
  end

  assign ack_d = do_swap;

  always_ff @(posedge clk) begin
    if (reset) begin
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      front_q <= front_d;
      pend_q  <= pend_d;
      if (re) rsel_q <= front_q;
    end
  end

  // INIT fills both banks; CLEAR and user writes hit the back bank.
  assign bank_we[0] = (state_q == ST_INIT) ||
                      (((state_q == ST_CLEAR) || user_we) && front_q);
  assign bank_we[1] = (state_q == ST_INIT) ||
                      (((state_q == ST_CLEAR) || user_we) && !front_q);

  fb_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (bank_we[0]),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (re && rd_ok),
    .raddr_i (read_addr),
    .rdata_o (rd0)
  );

  fb_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (bank_we[1]),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (re && rd_ok),
    .raddr_i (read_addr),
    .rdata_o (rd1)
  );

  assign front_sel = front_q;
  assign data_out  = oor_q ? CLEAR_VAL : (rsel_q ? rd1 : rd0);
`else
  logic [DATA_W-1:0] rd0;

  assign ack_d = swap_req;

  fb_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (sweeping || user_we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (re && rd_ok),
    .raddr_i (read_addr),
    .rdata_o (rd0)
  );

  assign front_sel = 1'b0;
  assign data_out  = oor_q ? CLEAR_VAL : rd0;
`endif

endmodule
